// File: rtl/shrg_pkg.sv
// Shared constants and helpers for the parametrised shift register family.
package shrg_pkg;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Counter width able to hold 0..N/S.
   function automatic int shrg_cw(input int n, input int s);
      return $clog2(n / s + 1);
   endfunction

endpackage

// File: rtl/shrg_step.sv
// One shift step: next buffer value and the lane ejected by the step in the
// requested direction. Purely combinational so it can be replicated per channel.
module shrg_step
   import shrg_pkg::*;
#(
   parameter int N = 8,
   parameter int S = 1
) (
   input  logic [N-1:0] buf_cur,
   input  logic [S-1:0] data,
   input  logic         dir,
   input  logic         rot,
   output logic [N-1:0] buf_nxt,
   output logic [S-1:0] ejected
);

   logic [S-1:0] ins;

   always_comb begin
      ejected = buf_cur[N-1:N-S];
      buf_nxt = buf_cur;
      if (dir == DIR_RIGHT) begin
         ejected = buf_cur[S-1:0];
      end
      // Rotate feeds the ejected lane back in at the opposite end.
      ins = rot ? ejected : data;
      if (dir == DIR_RIGHT) begin
         buf_nxt = {ins, buf_cur[N-1:S]};
      end else begin
         buf_nxt = {buf_cur[N-S-1:0], ins};
      end
   end

endmodule

// File: rtl/shrg_uni.sv
// Universal S-bit-lane shift register with step counter, word-complete pulse
// and an output latch that can auto-capture each completed word.
module shrg_uni
   import shrg_pkg::*;
#(
   parameter int N        = 8,
   parameter int S        = 1,
   parameter int AUTO_SET = 1,
   localparam int CW      = shrg_cw(N, S)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [S-1:0]  data,
   input  logic [N-1:0]  i,
   input  logic          wri,
   input  logic          shift,
   input  logic          dir,
   input  logic          rot,
   input  logic          set,
   output logic [N-1:0]  o,
   output logic [S-1:0]  so,
   output logic [CW-1:0] cnt,
   output logic          done
);

   localparam int            K        = N / S;
   localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

   if (N < 2 || S < 1 || S >= N || (N % S) != 0) begin : g_param_err
      $error("shrg_uni: need N>=2, 1<=S<N and N divisible by S");
   end

   logic [N-1:0] buf_q;
   logic [N-1:0] buf_nxt;
   logic         step;
   logic         word_done;

   shrg_step #(
      .N(N),
      .S(S)
   ) u_step (
      .buf_cur(buf_q),
      .data   (data),
      .dir    (dir),
      .rot    (rot),
      .buf_nxt(buf_nxt),
      .ejected(so)
   );

   // A load always wins, so a shift only counts as a step without wri.
   assign step      = shift && !wri;
   assign word_done = step && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= word_done;
         if (wri) begin
            buf_q <= i;
            cnt   <= '0;
         end else if (shift) begin
            buf_q <= buf_nxt;
            cnt   <= word_done ? '0 : CW'(cnt + 1'b1);
         end
      end
   end

   // Auto-capture takes the freshly assembled word; explicit set takes the
   // buffer as it was before this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o <= '0;
      end else if ((AUTO_SET != 0) && word_done) begin
         o <= buf_nxt;
      end else if (set) begin
         o <= buf_q;
      end
   end

endmodule

// File: tb/tb_shrg_uni.sv
// Bench for shrg_uni: directed scenarios plus random traffic on two instances,
// each compared every cycle against an arithmetic model of the register.
module tb_shrg_uni;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: N=8, S=1, AUTO_SET=1
   logic       a_data, a_wri, a_shift, a_dir, a_rot, a_set;
   logic [7:0] a_i, a_o;
   logic       a_so, a_done;
   logic [3:0] a_cnt;
   // Instance B: N=8, S=2, AUTO_SET=0
   logic [1:0] b_data;
   logic       b_wri, b_shift, b_dir, b_rot, b_set;
   logic [7:0] b_i, b_o;
   logic [1:0] b_so;
   logic       b_done;
   logic [2:0] b_cnt;

   shrg_uni #(.N(8), .S(1), .AUTO_SET(1)) dut_a (
      .clk(clk), .reset(reset), .data(a_data), .i(a_i), .wri(a_wri),
      .shift(a_shift), .dir(a_dir), .rot(a_rot), .set(a_set),
      .o(a_o), .so(a_so), .cnt(a_cnt), .done(a_done));

   shrg_uni #(.N(8), .S(2), .AUTO_SET(0)) dut_b (
      .clk(clk), .reset(reset), .data(b_data), .i(b_i), .wri(b_wri),
      .shift(b_shift), .dir(b_dir), .rot(b_rot), .set(b_set),
      .o(b_o), .so(b_so), .cnt(b_cnt), .done(b_done));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is an integer, shifts are multiply/divide.
   int ma_b, ma_o, ma_cnt, ma_done;
   int mb_b, mb_o, mb_cnt, mb_done;

   function automatic void mstep(input int n, input int s, input int aut,
                                 input int wri, input int shift, input int dir,
                                 input int rot, input int set, input int data,
                                 input int ival, inout int b, inout int o,
                                 inout int cnt, output int done);
      int old, ej, ins;
      bit complete;
      old = b;
      complete = 0;
      if (wri != 0) begin
         b = ival;
         cnt = 0;
      end else if (shift != 0) begin
         ej  = (dir != 0) ? old % (1 << s) : old / (1 << (n - s));
         ins = (rot != 0) ? ej : data;
         if (dir != 0) b = old / (1 << s) + ins * (1 << (n - s));
         else          b = (old * (1 << s) + ins) % (1 << n);
         cnt = cnt + 1;
         if (cnt == n / s) begin
            cnt = 0;
            complete = 1;
         end
      end
      done = complete ? 1 : 0;
      if (complete && aut != 0) o = b;
      else if (set != 0)        o = old;
   endfunction

   function automatic int exp_so(input int n, input int s, input int b, input int dir);
      return (dir != 0) ? b % (1 << s) : b / (1 << (n - s));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma_b = 0; ma_o = 0; ma_cnt = 0; ma_done = 0;
         mb_b = 0; mb_o = 0; mb_cnt = 0; mb_done = 0;
      end else begin
         mstep(8, 1, 1, int'(a_wri), int'(a_shift), int'(a_dir), int'(a_rot),
               int'(a_set), int'(a_data), int'(a_i), ma_b, ma_o, ma_cnt, ma_done);
         mstep(8, 2, 0, int'(b_wri), int'(b_shift), int'(b_dir), int'(b_rot),
               int'(b_set), int'(b_data), int'(b_i), mb_b, mb_o, mb_cnt, mb_done);
      end
   end

   always @(negedge clk) begin
      check("a_o",    int'(a_o),    ma_o);
      check("a_cnt",  int'(a_cnt),  ma_cnt);
      check("a_done", int'(a_done), ma_done);
      check("a_so",   int'(a_so),   exp_so(8, 1, ma_b, int'(a_dir)));
      check("b_o",    int'(b_o),    mb_o);
      check("b_cnt",  int'(b_cnt),  mb_cnt);
      check("b_done", int'(b_done), mb_done);
      check("b_so",   int'(b_so),   exp_so(8, 2, mb_b, int'(b_dir)));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] pat;
   logic [1:0] so_seq [4];

   initial begin
      reset = 1'b0;
      a_data = 0; a_wri = 0; a_shift = 0; a_dir = 0; a_rot = 0; a_set = 0; a_i = 0;
      b_data = 0; b_wri = 0; b_shift = 0; b_dir = 0; b_rot = 0; b_set = 0; b_i = 0;
      tick(); tick();
      check("rst_o",    int'(a_o), 0);
      check("rst_cnt",  int'(a_cnt), 0);
      check("rst_done", int'(a_done), 0);
      reset = 1'b1;

      // Deserialise 1,0,1,1,0,0,1,0 MSB-first into 8'hB2.
      pat = 8'hB2;
      for (int k = 0; k < 8; k++) begin
         a_shift = 1; a_dir = 0; a_data = pat[7-k];
         tick();
         check("t1_done", int'(a_done), (k == 7) ? 1 : 0);
      end
      check("t1_o", int'(a_o), 8'hB2);
      check("t1_cnt", int'(a_cnt), 0);
      a_shift = 0;
      tick();
      check("t1_done_clr", int'(a_done), 0);

      // B: latch E7 into o, then serialise C6 to the right with zero fill.
      b_wri = 1; b_i = 8'hE7; tick();
      b_wri = 0; b_set = 1; tick();
      b_set = 0;
      check("t4_b_set", int'(b_o), 8'hE7);
      so_seq[0] = 2'b10; so_seq[1] = 2'b01; so_seq[2] = 2'b00; so_seq[3] = 2'b11;
      b_wri = 1; b_i = 8'hC6; b_dir = 1; tick();
      b_wri = 0;
      for (int k = 0; k < 4; k++) begin
         check("t2_so", int'(b_so), int'(so_seq[k]));
         b_shift = 1; b_data = 2'b00;
         tick();
         check("t2_done", int'(b_done), (k == 3) ? 1 : 0);
      end
      b_shift = 0;
      check("t4_noauto_o", int'(b_o), 8'hE7);
      b_set = 1; tick(); b_set = 0;
      check("t2_buf_zero", int'(b_o), 0);

      // A: rotate 8'h81 left by one and then by a full word.
      a_wri = 1; a_i = 8'h81; tick();
      a_wri = 0; a_rot = 1; a_shift = 1; tick();
      a_shift = 0; a_set = 1; tick();
      a_set = 0;
      check("t3_rot1", int'(a_o), 8'h03);
      a_shift = 1;
      for (int k = 0; k < 7; k++) begin
         tick();
         check("t3_done", int'(a_done), (k == 6) ? 1 : 0);
      end
      a_shift = 0; a_rot = 0;
      check("t3_restore", int'(a_o), 8'h81);

      // Simultaneous load+shift, and set+shift capturing the pre-shift buffer.
      a_wri = 1; a_shift = 1; a_i = 8'h5A; tick();
      check("t4_wri_cnt", int'(a_cnt), 0);
      a_wri = 0; a_shift = 0; a_set = 1; tick();
      check("t4_wri_buf", int'(a_o), 8'h5A);
      a_set = 0; a_wri = 1; a_i = 8'h3C; tick();
      a_wri = 0; a_shift = 1; a_set = 1; a_data = 1; tick();
      a_shift = 0; a_set = 0;
      check("t4_set_old", int'(a_o), 8'h3C);
      check("t4_set_cnt", int'(a_cnt), 1);

      // Asynchronous reset mid-word.
      a_wri = 1; a_i = 8'h00; tick(); a_wri = 0;
      a_shift = 1;
      for (int k = 0; k < 5; k++) begin
         a_data = 1'($urandom_range(0, 1));
         tick();
      end
      #1 reset = 1'b0;
      #1;
      check("t5_o",    int'(a_o), 0);
      check("t5_cnt",  int'(a_cnt), 0);
      check("t5_done", int'(a_done), 0);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a_data = 1'($urandom_range(0, 1));
         tick();
         check("t5_done", int'(a_done), (k == 7) ? 1 : 0);
      end

      // 24 back-to-back steps: pulses on steps 8, 16 and 24 only.
      for (int k = 1; k <= 24; k++) begin
         a_data = 1'($urandom_range(0, 1));
         a_dir  = 1'($urandom_range(0, 1));
         tick();
         check("t6_done", int'(a_done), (k % 8 == 0) ? 1 : 0);
      end
      a_shift = 0;

      // Random traffic on both instances.
      for (int k = 0; k < 600; k++) begin
         a_wri   = ($urandom_range(0, 15) == 0);
         a_shift = ($urandom_range(0, 3) != 0);
         a_dir   = 1'($urandom_range(0, 1));
         a_rot   = ($urandom_range(0, 3) == 0);
         a_set   = ($urandom_range(0, 7) == 0);
         a_data  = 1'($urandom_range(0, 1));
         a_i     = 8'($urandom);
         b_wri   = ($urandom_range(0, 15) == 0);
         b_shift = ($urandom_range(0, 3) != 0);
         b_dir   = 1'($urandom_range(0, 1));
         b_rot   = ($urandom_range(0, 3) == 0);
         b_set   = ($urandom_range(0, 7) == 0);
         b_data  = 2'($urandom);
         b_i     = 8'($urandom);
         if (k == 300) begin
            #2 reset = 1'b0;
            #2 reset = 1'b1;
         end
         tick();
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
